// File: rtl/cordic_share_sched_if.sv
// cordic_share_sched_if: request, core and result signals of the shared CORDIC scheduler
interface cordic_share_sched_if #(
    parameter int COORD_W     = 11,
    parameter int ANGLE_DEPTH = 10
);
    logic [2:0]               req_valid;
    logic [2:0]               req_ready;
    logic [3*COORD_W-1:0]     req_dx;
    logic [3*COORD_W-1:0]     req_dy;
    logic                     core_start;
    logic [COORD_W-1:0]       core_x;
    logic [COORD_W-1:0]       core_y;
    logic                     core_done;
    logic [ANGLE_DEPTH-1:0]   core_angle;
    logic [3*ANGLE_DEPTH-1:0] angle_out;
    logic [2:0]               angle_rdy;
    logic                     frame_rdy;
    logic                     busy;
    logic                     err_timeout;

    modport master (
        output req_valid, req_dx, req_dy, core_done, core_angle,
        input  req_ready, core_start, core_x, core_y, angle_out, angle_rdy, frame_rdy, busy, err_timeout
    );

    modport slave (
        input  req_valid, req_dx, req_dy, core_done, core_angle,
        output req_ready, core_start, core_x, core_y, angle_out, angle_rdy, frame_rdy, busy, err_timeout
    );
endinterface

// File: rtl/cordic_share_sched.sv
// cordic_share_sched: round-robin sharing of one CORDIC core among three limb channels,
// one vector per channel per frame, with per-channel result pulses and a frame pulse.
module cordic_share_sched #(
    parameter int COORD_W     = 11,
    parameter int ANGLE_DEPTH = 10,
    parameter int TIMEOUT_CYC = 64
) (
    input logic clk,
    input logic rst,
    cordic_share_sched_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

    state_t                   state, state_nx;
    logic [2:0]               pending, delivered, gmask, acc;
    logic [1:0]               g, rr, rr1, rr2, pick;
    logic [CNT_W-1:0]         cnt;
    logic                     timed_out, frame, err;
    logic [COORD_W-1:0]       hold_dx [3];
    logic [COORD_W-1:0]       hold_dy [3];
    logic [COORD_W-1:0]       x_q, y_q;
    logic [3*ANGLE_DEPTH-1:0] angle_q;

    assign gmask     = 3'b001 << g;
    assign rr1       = rr == 2'd2 ? 2'd0 : rr + 2'd1;
    assign rr2       = rr == 2'd0 ? 2'd2 : rr - 2'd1;
    assign pick      = pending[rr] ? rr : pending[rr1] ? rr1 : rr2;
    assign timed_out = cnt == CNT_W'(TIMEOUT_CYC - 1);
    assign frame     = (delivered | gmask) == 3'b111;

    // The in-flight channel stays blocked until its result has been delivered.
    assign bus.req_ready = ~(pending | delivered | ((state == WAIT || state == DELIVER) ? gmask : 3'b000));
    assign acc           = bus.req_valid & bus.req_ready;

    assign bus.core_start  = state == ISSUE;
    assign bus.core_x      = x_q;
    assign bus.core_y      = y_q;
    assign bus.busy        = state == ISSUE || state == WAIT;
    assign bus.angle_rdy   = state == DELIVER ? gmask : 3'b000;
    assign bus.frame_rdy   = state == DELIVER && frame;
    assign bus.angle_out   = angle_q;
    assign bus.err_timeout = err;

    always_comb begin
        state_nx = state == IDLE  ? (|pending ? ISSUE : IDLE) :
                   state == ISSUE ? WAIT :
                   state == WAIT  ? ((bus.core_done || timed_out) ? DELIVER : WAIT) :
                   IDLE;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (acc[i]) begin
                hold_dx[i] <= bus.req_dx[i*COORD_W +: COORD_W];
                hold_dy[i] <= bus.req_dy[i*COORD_W +: COORD_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            delivered <= '0;
            angle_q   <= '0;
            err       <= 1'b0;
            cnt       <= '0;
            rr        <= '0;
            g         <= '0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            state   <= state_nx;
            pending <= (pending | acc) & ~(state == ISSUE ? gmask : 3'b000);
            cnt     <= state == WAIT ? cnt + 1'b1 : '0;
            if (state == IDLE && |pending) begin
                g   <= pick;
                x_q <= hold_dx[pick];
                y_q <= hold_dy[pick];
            end
            if (state == ISSUE)
                rr <= g == 2'd2 ? 2'd0 : g + 2'd1;
            // A timed-out job still delivers (a zero angle) so the frame can complete.
            if (state == WAIT && (bus.core_done || timed_out)) begin
                angle_q[g*ANGLE_DEPTH +: ANGLE_DEPTH] <= bus.core_done ? bus.core_angle : '0;
                err <= err | !bus.core_done;
            end
            if (state == DELIVER)
                delivered <= frame ? 3'b000 : delivered | gmask;
        end
    end
endmodule

// File: tb/tb_cordic_share_sched.sv
// tb_cordic_share_sched: randomized scenarios against a set/queue-based scheduler model
// with a latency-programmable core model.
module tb_cordic_share_sched;
    localparam int CW = 11;
    localparam int AW = 10;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    cordic_share_sched_if #(.COORD_W(CW), .ANGLE_DEPTH(AW)) bus();
    cordic_share_sched #(.COORD_W(CW), .ANGLE_DEPTH(AW), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic signed [CW-1:0] dx [3];
    logic signed [CW-1:0] dy [3];
    assign bus.req_dx = {dx[2], dx[1], dx[0]};
    assign bus.req_dy = {dy[2], dy[1], dy[0]};

    int          done_at = -1;
    logic [AW-1:0] job_ang = '0;
    int          lat      = 12;
    bit          lat_rand = 0;
    int          drop_ch  = -1;

    // Core model: a strobe in the cycle chosen when the job was issued.
    initial begin
        bus.core_done  = 1'b0;
        bus.core_angle = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            bus.core_done  = cyc == done_at;
            bus.core_angle = job_ang;
        end
    end

    logic [2:0]    m_pend = '0, m_prev = '0, m_del = '0;
    bit            infl_v = 0, infl_to = 0, idle_prev = 1, exp_err = 0;
    int            infl_ch = 0, rr_m = 0, deliver_at = 0;
    logic [CW-1:0] hx [3] = '{default: '0};
    logic [CW-1:0] hy [3] = '{default: '0};
    logic [AW-1:0] exp_ang [3] = '{default: '0};

    logic [CW-1:0] sx [$];
    logic [CW-1:0] sy [$];
    int            sc [$];
    int            rdy_log [$];
    int            rdy_cyc [$];

    function automatic int arb(logic [2:0] p, int r);
        for (int k = 0; k < 3; k++) if (p[(r + k) % 3]) return (r + k) % 3;
        return 0;
    endfunction

    always @(negedge clk) begin : sb
        logic [2:0] er, oh, erdy, acc;
        logic       es, eb, ef;
        int         g, l;
        if (rst) begin
            m_pend = '0; m_prev = '0; m_del = '0; infl_v = 0; idle_prev = 1; rr_m = 0; exp_err = 0;
            for (int i = 0; i < 3; i++) exp_ang[i] = '0;
        end else begin
            oh = infl_v ? 3'b001 << infl_ch : 3'b000;
            er = ~(m_pend | m_del | oh);
            total++;
            if (bus.req_ready !== er) begin
                bad++; $display("FAIL req_ready cyc=%0d got=%b want=%b", cyc, bus.req_ready, er);
            end
            es = idle_prev && (m_prev != 3'b000);
            total++;
            if (bus.core_start !== es) begin
                bad++; $display("FAIL core_start cyc=%0d got=%b want=%b", cyc, bus.core_start, es);
            end
            if (es) begin
                g = arb(m_prev, rr_m);
                total++;
                if (bus.core_x !== hx[g] || bus.core_y !== hy[g]) begin
                    bad++; $display("FAIL core_xy cyc=%0d got=%0d,%0d want ch%0d %0d,%0d",
                                    cyc, bus.core_x, bus.core_y, g, hx[g], hy[g]);
                end
                m_pend[g] = 1'b0; rr_m = (g + 1) % 3; infl_v = 1; infl_ch = g; infl_to = g == drop_ch;
                l = lat_rand ? int'($urandom_range(1, 16)) : lat;
                job_ang    = AW'($urandom_range(1, (1 << AW) - 1));
                done_at    = infl_to ? -1 : cyc + l;
                deliver_at = infl_to ? cyc + 65 : cyc + l + 1;
                oh = 3'b001 << g;
            end
            eb   = es || (infl_v && cyc != deliver_at);
            erdy = (infl_v && cyc == deliver_at) ? oh : 3'b000;
            ef   = 1'b0;
            if (erdy != 3'b000) begin
                exp_ang[infl_ch] = infl_to ? '0 : job_ang;
                exp_err = exp_err | infl_to;
                ef = (m_del | erdy) == 3'b111;
                m_del = ef ? 3'b000 : m_del | erdy;
                infl_v = 0;
            end
            total++;
            if (bus.angle_rdy !== erdy) begin
                bad++; $display("FAIL angle_rdy cyc=%0d got=%b want=%b", cyc, bus.angle_rdy, erdy);
            end
            total++;
            if (bus.frame_rdy !== ef) begin
                bad++; $display("FAIL frame_rdy cyc=%0d got=%b want=%b", cyc, bus.frame_rdy, ef);
            end
            total++;
            if (bus.busy !== eb) begin
                bad++; $display("FAIL busy cyc=%0d got=%b want=%b", cyc, bus.busy, eb);
            end
            total++;
            if (bus.err_timeout !== exp_err) begin
                bad++; $display("FAIL err_timeout cyc=%0d got=%b want=%b", cyc, bus.err_timeout, exp_err);
            end
            total++;
            if (bus.angle_out !== {exp_ang[2], exp_ang[1], exp_ang[0]}) begin
                bad++; $display("FAIL angle_out cyc=%0d got=%h want=%h", cyc, bus.angle_out,
                                {exp_ang[2], exp_ang[1], exp_ang[0]});
            end
            idle_prev = !eb && erdy == 3'b000;
            acc = bus.req_valid & er;
            for (int i = 0; i < 3; i++) if (acc[i]) begin hx[i] = dx[i]; hy[i] = dy[i]; end
            m_prev = m_pend;
            m_pend = m_pend | acc;
            if (bus.core_start === 1'b1) begin sx.push_back(bus.core_x); sy.push_back(bus.core_y); sc.push_back(cyc); end
            if (bus.angle_rdy != 3'b000) begin
                rdy_log.push_back(bus.angle_rdy[0] ? 0 : bus.angle_rdy[1] ? 1 : 2);
                rdy_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        sx.delete(); sy.delete(); sc.delete(); rdy_log.delete(); rdy_cyc.delete();
    endtask

    task automatic wait_frame(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            if (bus.frame_rdy === 1'b1) break;
            n++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if (bus.req_ready !== 3'b111) begin bad++; $display("FAIL reset_ready got=%b want=111", bus.req_ready); end
        total++;
        if ({bus.core_start, bus.angle_rdy, bus.frame_rdy, bus.busy, bus.err_timeout} !== 7'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=0",
                            {bus.core_start, bus.angle_rdy, bus.frame_rdy, bus.busy, bus.err_timeout});
        end
        total++;
        if (bus.angle_out !== '0 || bus.core_x !== '0 || bus.core_y !== '0) begin
            bad++; $display("FAIL reset_data got=%h/%h/%h want=0", bus.angle_out, bus.core_x, bus.core_y);
        end
        tick();
        rst = 0;
    endtask

    task automatic test_single_frame();
        int ex [3] = '{10, 0, -10};
        int ey [3] = '{0, 10, 0};
        int n, a;
        clear_logs();
        lat = 12; lat_rand = 0;
        tick();
        for (int i = 0; i < 3; i++) begin dx[i] = CW'(ex[i]); dy[i] = CW'(ey[i]); end
        bus.req_valid = 3'b111;
        a = cyc + 1;
        tick();
        bus.req_valid = 3'b000;
        wait_frame(300, n);
        total++;
        if (n >= 300 || bus.angle_rdy !== 3'b100) begin
            bad++; $display("FAIL t1_frame waited=%0d rdy=%b want=100", n, bus.angle_rdy);
        end
        tick();
        total++;
        if (sx.size() != 3) begin bad++; $display("FAIL t1_starts got=%0d want=3", sx.size()); end
        else for (int i = 0; i < 3; i++) begin
            total++;
            if (sx[i] !== CW'(ex[i]) || sy[i] !== CW'(ey[i])) begin
                bad++; $display("FAIL t1_order idx=%0d got=%0d,%0d want=%0d,%0d", i, sx[i], sy[i], ex[i], ey[i]);
            end
        end
        total++;
        if (rdy_log.size() != 3 || rdy_log[0] != 0 || rdy_log[1] != 1 || rdy_log[2] != 2) begin
            bad++; $display("FAIL t1_rdy_order got=%p want=0,1,2", rdy_log);
        end
        total++;
        if (rdy_cyc.size() == 0 || rdy_cyc[0] != a + lat + 2) begin
            bad++; $display("FAIL t1_latency got=%p want=%0d", rdy_cyc, a + lat + 2);
        end
    endtask

    task automatic test_round_robin();
        logic [CW-1:0] x0, x1;
        int n;
        clear_logs();
        tick();
        dx[0] = CW'($urandom); dx[1] = dx[0] + 1'b1;
        dy[0] = CW'($urandom); dy[1] = CW'($urandom);
        x0 = dx[0]; x1 = dx[1];
        bus.req_valid = 3'b011;
        tick();
        bus.req_valid = 3'b000;
        repeat (40) tick();
        dx[2] = CW'($urandom); dy[2] = CW'($urandom);
        bus.req_valid = 3'b100;
        tick();
        bus.req_valid = 3'b000;
        wait_frame(300, n);
        total++;
        if (n >= 300) begin bad++; $display("FAIL t2_frame waited=%0d", n); end
        tick();
        total++;
        if (sx.size() != 3 || sx[0] !== x0 || sx[1] !== x1) begin
            bad++; $display("FAIL t2_rr_order got=%p want=%0d,%0d,...", sx, x0, x1);
        end
    endtask

    task automatic test_double_submit();
        int n, zeros;
        bit armed, done0;
        clear_logs();
        tick();
        for (int i = 0; i < 3; i++) begin dx[i] = CW'($urandom); dy[i] = CW'($urandom); end
        bus.req_valid = 3'b111;
        armed = 0; done0 = 0; n = 0;
        for (int f = 0; f < 2; ) begin
            @(negedge clk);
            n++;
            if (n > 400) break;
            if (armed) begin
                total++;
                if (bus.req_ready[0] !== 1'b0) begin bad++; $display("FAIL t3_ready0_after_rdy got=%b want=0", bus.req_ready[0]); end
                armed = 0; done0 = 1;
            end
            if (bus.angle_rdy[0] === 1'b1 && !done0) armed = 1;
            if (bus.frame_rdy === 1'b1) begin
                f++;
                total++;
                if (bus.req_ready !== 3'b000) begin bad++; $display("FAIL t3_ready_at_frame got=%b want=000", bus.req_ready); end
            end
        end
        tick();
        bus.req_valid = 3'b000;
        @(negedge clk);
        total++;
        if (bus.req_ready !== 3'b111) begin bad++; $display("FAIL t3_ready_after_frame got=%b want=111", bus.req_ready); end
        zeros = 0;
        foreach (rdy_log[i]) if (rdy_log[i] == 0) zeros++;
        total++;
        if (n > 400 || zeros != 2 || sx.size() != 6) begin
            bad++; $display("FAIL t3_one_issue_per_frame cycles=%0d ch0_rdy=%0d starts=%0d want 2/6", n, zeros, sx.size());
        end
    endtask

    task automatic test_timeout();
        int n;
        clear_logs();
        drop_ch = 1;
        tick();
        for (int i = 0; i < 3; i++) begin dx[i] = CW'($urandom); dy[i] = CW'($urandom); end
        bus.req_valid = 3'b111;
        tick();
        bus.req_valid = 3'b000;
        wait_frame(400, n);
        total++;
        if (n >= 400) begin bad++; $display("FAIL t4_frame waited=%0d", n); end
        tick();
        drop_ch = -1;
        total++;
        if (bus.err_timeout !== 1'b1 || bus.angle_out[AW +: AW] !== '0) begin
            bad++; $display("FAIL t4_timeout err=%b angle1=%0d want 1/0", bus.err_timeout, bus.angle_out[AW +: AW]);
        end
        total++;
        if (rdy_log.size() != 3 || rdy_log[1] != 1 || rdy_log[2] != 2 || rdy_cyc[1] - sc[1] != 65) begin
            bad++; $display("FAIL t4_served rdy=%p cyc=%p starts=%p", rdy_log, rdy_cyc, sc);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_logs();
        tick();
        dx[0] = CW'($urandom); dy[0] = CW'($urandom);
        bus.req_valid = 3'b001;
        tick();
        bus.req_valid = 3'b000;
        n = 0;
        while (n < 20 && bus.core_start !== 1'b1) begin @(negedge clk); n++; end
        total++;
        if (n >= 20) begin bad++; $display("FAIL t5_no_issue waited=%0d", n); end
        repeat (4) tick();
        rst = 1;
        done_at = cyc + 4;
        repeat (2) tick();
        rst = 0;
        @(negedge clk);
        total++;
        if (bus.req_ready !== 3'b111 || bus.angle_out !== '0 || bus.err_timeout !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL t5_after_reset ready=%b angle=%h err=%b busy=%b", bus.req_ready, bus.angle_out,
                            bus.err_timeout, bus.busy);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (bus.angle_rdy !== 3'b000 || bus.core_start !== 1'b0 || bus.busy !== 1'b0) begin
                bad++; $display("FAIL t5_late_done cyc=%0d rdy=%b start=%b busy=%b", cyc, bus.angle_rdy,
                                bus.core_start, bus.busy);
            end
        end
    endtask

    task automatic test_long_run();
        int cnt [3] = '{0, 0, 0};
        int fr = 0;
        int n = 0;
        clear_logs();
        lat_rand = 1;
        while (fr < 22 && n < 20000) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                bus.req_valid[i] = cnt[i] < 22 && $urandom_range(0, 1) == 1;
                dx[i] = CW'($urandom); dy[i] = CW'($urandom);
            end
            @(negedge clk);
            n++;
            if (bus.frame_rdy === 1'b1) fr++;
            for (int i = 0; i < 3; i++) if (bus.req_valid[i] && bus.req_ready[i]) cnt[i]++;
        end
        tick();
        bus.req_valid = 3'b000;
        repeat (3) tick();
        total++;
        if (fr != 22 || rdy_log.size() != 66) begin
            bad++; $display("FAIL t6_counts frames=%0d rdy=%0d want 22/66", fr, rdy_log.size());
        end
        total++;
        if (bus.err_timeout !== 1'b0) begin bad++; $display("FAIL t6_err got=%b want=0", bus.err_timeout); end
        lat_rand = 0;
    endtask

    initial begin
        bus.req_valid = 3'b000;
        for (int i = 0; i < 3; i++) begin dx[i] = '0; dy[i] = '0; end
        test_reset();
        test_single_frame();
        test_round_robin();
        test_double_submit();
        test_timeout();
        test_reset_mid();
        test_long_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d total=%0d bad=%0d", cyc, total, bad);
        $fatal(1, "simulation time limit");
    end
endmodule
